// File: rtl/cpu_sequencer.sv
// Instruction fetch/decode sequencer: fetches into IR', registers the ALU opcode,
// sequences FETCH/EXEC1/EXEC2/HALT and owns the program counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | request instruction word, latch IR'/opcode on mem_ready
// S_EXEC1 | first execute cycle (always exactly one cycle)
// S_EXEC2 | second execute cycle; memory class waits here for mem_ready
// S_HALT  | stopped after STP, waiting for resume
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        resume,
  output logic        mem_req,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic [15:0] instruction,
  output logic [5:0]  encoded_opcode,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal_op
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [5:0] OP_MAX_LEGAL = 6'b111000;
  localparam logic [5:0] OP_ILLEGAL   = 6'b111111;

  state_t state, state_nxt;
  logic   run;
  logic   illegal_q;
  logic   is_mem, is_mul, is_stp;
  logic   fetch_done;
  logic   exec_exit;

  // run holds fetch/mem_req low while in reset and until the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      state <= S_FETCH;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
    end
  end

  always_comb begin
    is_mem = 1'b0;
    is_mul = 1'b0;
    is_stp = 1'b0;
    case (encoded_opcode)
      6'b011001, 6'b011010, 6'b011011, 6'b011100,
      6'b100100, 6'b100101, 6'b100110: is_mem = 1'b1;
      6'b100001, 6'b100010:            is_mul = 1'b1;
      6'b100111:                       is_stp = 1'b1;
      default: ;
    endcase
  end

  assign fetch      = run && (state == S_FETCH);
  assign exec1      = (state == S_EXEC1);
  assign exec2      = (state == S_EXEC2);
  assign halted     = (state == S_HALT);
  assign mem_req    = fetch || (exec2 && is_mem);
  assign illegal_op = exec1 && illegal_q;
  assign fetch_done = fetch && mem_ready;

  always_comb begin
    state_nxt = state;
    exec_exit = 1'b0;
    case (state)
      S_FETCH: begin
        if (fetch_done) state_nxt = S_EXEC1;
      end
      S_EXEC1: begin
        if (is_mem || is_mul) begin
          state_nxt = S_EXEC2;
        end else if (is_stp) begin
          state_nxt = S_HALT;
          exec_exit = 1'b1;
        end else begin
          state_nxt = S_FETCH;
          exec_exit = 1'b1;
        end
      end
      S_EXEC2: begin
        if (is_mul || mem_ready) begin
          state_nxt = S_FETCH;
          exec_exit = 1'b1;
        end
      end
      S_HALT: begin
        if (resume) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      instruction    <= 16'h0000;
      encoded_opcode <= OP_ILLEGAL;
      illegal_q      <= 1'b0;
    end else if (fetch_done) begin
      pc          <= pc + 16'd1;
      instruction <= mem_data;
      if (mem_data[15:10] <= OP_MAX_LEGAL) begin
        encoded_opcode <= mem_data[15:10];
        illegal_q      <= 1'b0;
      end else begin
        encoded_opcode <= OP_ILLEGAL;
        illegal_q      <= 1'b1;
      end
    end else if (exec_exit && pc_load) begin
      pc <= pc_load_value;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed and random instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] mem_data = 16'h0000;
  logic        mem_ready = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic        resume = 1'b0;
  logic        mem_req, fetch, exec1, exec2, halted, illegal_op;
  logic [15:0] instruction, pc;
  logic [5:0]  encoded_opcode;

  cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_data(mem_data), .mem_ready(mem_ready),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .resume(resume),
    .mem_req(mem_req), .fetch(fetch), .exec1(exec1), .exec2(exec2),
    .instruction(instruction), .encoded_opcode(encoded_opcode), .pc(pc),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // flags = {fetch, exec1, exec2, halted, mem_req}
  localparam logic [4:0] FL_NONE = 5'b00000;
  localparam logic [4:0] FL_F    = 5'b10001;
  localparam logic [4:0] FL_E1   = 5'b01000;
  localparam logic [4:0] FL_E2   = 5'b00100;
  localparam logic [4:0] FL_E2M  = 5'b00101;
  localparam logic [4:0] FL_H    = 5'b00010;

  int tests = 0;
  int fails = 0;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ir = 16'h0000;
  logic [5:0]  m_eop = 6'b111111;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [4:0] flags, input logic ill);
    chk({tag, ".flags"}, {11'd0, fetch, exec1, exec2, halted, mem_req}, {11'd0, flags});
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".ir"}, instruction, m_ir);
    chk({tag, ".opcode"}, {10'd0, encoded_opcode}, {10'd0, m_eop});
    chk({tag, ".illegal"}, {15'd0, illegal_op}, {15'd0, ill});
  endtask

  // 0 single-cycle, 1 multiply, 2 memory, 3 halt
  function automatic int op_class(input logic [5:0] op);
    if (op inside {6'b011001, 6'b011010, 6'b011011, 6'b011100,
                   6'b100100, 6'b100101, 6'b100110}) return 2;
    if (op inside {6'b100001, 6'b100010}) return 1;
    if (op == 6'b100111) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_ir  = 16'h0000;
    m_eop = 6'b111111;
  endtask

  // waits = EXEC2 wait cycles for memory ops, HALT cycles (>=1) for STP
  task automatic run_instr(input logic [15:0] word, input int stall, input int waits,
                           input bit jmp, input logic [15:0] tgt, input bit rst_mid);
    logic [5:0] op;
    int cls;
    op  = word[15:10];
    cls = op_class(op);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk_cyc("stall", FL_F, 1'b0);
      mem_ready = 1'b0; mem_data = 16'($urandom);
      pc_load = 1'($urandom); pc_load_value = 16'($urandom); resume = 1'($urandom);
    end
    @(negedge clk);
    chk_cyc("fetch", FL_F, 1'b0);
    mem_ready = 1'b1; mem_data = word;
    pc_load = 1'($urandom); pc_load_value = 16'($urandom); resume = 1'($urandom);
    m_pc  = m_pc + 16'd1;
    m_ir  = word;
    m_eop = (op <= 6'b111000) ? op : 6'b111111;

    @(negedge clk);
    chk_cyc("exec1", FL_E1, op > 6'b111000);
    mem_ready = 1'($urandom); mem_data = 16'($urandom); resume = 1'($urandom);
    pc_load_value = tgt;
    if (cls == 0 || cls == 3) begin
      pc_load = jmp;
      if (jmp) m_pc = tgt;
    end else begin
      pc_load = 1'($urandom);
    end

    if (cls == 1) begin
      @(negedge clk);
      chk_cyc("mul", FL_E2, 1'b0);
      mem_ready = 1'($urandom); pc_load = jmp; pc_load_value = tgt;
      if (jmp) m_pc = tgt;
    end else if (cls == 2) begin
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        chk_cyc("wait", FL_E2M, 1'b0);
        mem_ready = 1'b0; mem_data = 16'($urandom);
        pc_load = 1'($urandom); pc_load_value = 16'($urandom);
        if (rst_mid) begin
          #2 rst_n = 1'b0;
          #1 model_reset();
          chk_cyc("reset_mid", FL_NONE, 1'b0);
          pc_load = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
      @(negedge clk);
      chk_cyc("memdone", FL_E2M, 1'b0);
      mem_ready = 1'b1; mem_data = 16'($urandom); pc_load = jmp; pc_load_value = tgt;
      if (jmp) m_pc = tgt;
    end else if (cls == 3) begin
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        chk_cyc("halt", FL_H, 1'b0);
        resume = (i == waits - 1);
        mem_ready = 1'($urandom); pc_load = 1'($urandom); pc_load_value = 16'($urandom);
      end
    end
  endtask

  initial begin
    logic [5:0] op;
    int cls;
    #1 rst_n = 1'b0;
    #2 model_reset();
    chk_cyc("reset", FL_NONE, 1'b0);
    repeat (2) @(negedge clk);
    chk_cyc("reset_hold", FL_NONE, 1'b0);
    rst_n = 1'b1;

    run_instr(16'h4400, 0, 0, 1'b0, 16'h0000, 1'b0);               // ADD
    run_instr(16'h2000 | 16'($urandom_range(0, 1023)), 3, 0, 1'b0, 16'h0, 1'b0); // INC
    run_instr(16'h6800, 0, 2, 1'b1, 16'h00A0, 1'b0);               // LOAD + jump
    run_instr(16'h8400, 1, 0, 1'b0, 16'h0000, 1'b0);               // MUL
    run_instr(16'h0000, 0, 0, 1'b1, 16'h1234, 1'b0);               // JMR
    run_instr(16'h9C00, 0, 10, 1'b0, 16'h0000, 1'b0);              // STP
    run_instr(16'hE800, 0, 0, 1'b0, 16'h0000, 1'b0);               // illegal 111010
    run_instr(16'hE000, 0, 0, 1'b0, 16'h0000, 1'b0);               // 111000, highest legal
    run_instr(16'h6800, 0, 3, 1'b0, 16'h0000, 1'b1);               // reset during wait
    run_instr(16'h0000, 0, 0, 1'b1, 16'hFFFF, 1'b0);               // JMR to FFFF
    run_instr(16'h4400, 0, 0, 1'b0, 16'h0000, 1'b0);               // wrap to 0000
    run_instr(16'h9C00, 0, 2, 1'b1, 16'h0BEE, 1'b0);               // STP with load
    run_instr(16'h8800, 0, 0, 1'b1, 16'h0C00, 1'b0);               // MLS + jump

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: op = 6'($urandom);
        1: op = (($urandom_range(0, 1)) != 0) ? 6'b100001 : 6'b100010;
        2: op = 6'(6'b011001 + 6'($urandom_range(0, 3)));
        default: op = (($urandom_range(0, 3)) == 0) ? 6'b100111 : 6'(6'b100100 + 6'($urandom_range(0, 2)));
      endcase
      cls = op_class(op);
      run_instr({op, 10'($urandom)}, $urandom_range(0, 2),
                (cls == 3) ? $urandom_range(1, 4) : $urandom_range(0, 3),
                1'($urandom), 16'($urandom), 1'b0);
    end
    @(negedge clk);
    chk_cyc("final", FL_F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
